pipelined_ripple_adder: RTL

// - N-bit add/subtract unit; the carry chain is split into STAGES equal slices with a register after each slice.
// - Sustains one operation per clock at full width (e.g. 128 bits), where a single-cycle ripple would limit the clock.
// - Valid/ready handshake on both sides, so it drops into streaming datapaths.
// - Results leave in issue order.
//

---
 rtl/pipelined_ripple_adder_if.sv | 41 ++++
 rtl/pipelined_ripple_adder.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipelined_ripple_adder_if.sv
`default_nettype none
// pipelined_ripple_adder_if: operand/result bundle with valid/ready on both sides. Rev 1.0
// The ovf wire and its modport entries exist only when PRA_OVERFLOW_EN is defined.
interface pipelined_ripple_adder_if #(
  parameter int N = 128
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         c_out;
`ifdef PRA_OVERFLOW_EN
  logic         ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
`else
  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`endif
endinterface
`default_nettype wire

// File: rtl/pipelined_ripple_adder.sv
`default_nettype none
// pipelined_ripple_adder: N-bit add/sub, carry chain cut into STAGES registered slices. Rev 1.0
// Optional macro PRA_OVERFLOW_EN adds the registered signed-overflow output ovf.
module pipelined_ripple_adder #(
  parameter int N      = 128,
  parameter int STAGES = 4
) (
  input  wire                      clk,
  input  wire                      rst_n,
  pipelined_ripple_adder_if.slave  bus
);

  localparam int W = N / STAGES;

  logic         w_adv;
  logic [N-1:0] w_b_eff;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign w_adv        = !g_stage[STAGES-1].r_vld || bus.out_ready;
  assign w_b_eff      = bus.sub ? ~bus.b : bus.b;
  assign bus.in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                 w_vld_in;
    logic                 w_cy_in;
    logic [W-1:0]         w_a;
    logic [W-1:0]         w_b;
    logic [W:0]           w_add;
    logic [(k+1)*W-1:0]   w_sum_nxt;
    logic                 r_vld;
    logic                 r_cy;
    logic [(k+1)*W-1:0]   r_sum;

    if (k == 0) begin : g_head
      assign w_vld_in  = bus.in_valid;
      assign w_cy_in   = bus.sub | bus.c_in;
      assign w_a       = bus.a[W-1:0];
      assign w_b       = w_b_eff[W-1:0];
      assign w_sum_nxt = w_add[W-1:0];
    end else begin : g_body
      assign w_vld_in  = g_stage[k-1].r_vld;
      assign w_cy_in   = g_stage[k-1].r_cy;
      assign w_a       = g_stage[k-1].g_skew.r_a[W-1:0];
      assign w_b       = g_stage[k-1].g_skew.r_b[W-1:0];
      assign w_sum_nxt = {w_add[W-1:0], g_stage[k-1].r_sum};
    end

    assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{W{1'b0}}, w_cy_in};

    // Data registers only load on a real op, so bubbles leave the last result visible.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_vld <= w_vld_in;
        if (w_vld_in) begin
          r_cy  <= w_add[W];
          r_sum <= w_sum_nxt;
        end
      end
    end

    // Unconsumed upper operand slices, shifted down one slice per stage.
    if (k < STAGES-1) begin : g_skew
      localparam int RW = (STAGES-1-k) * W;
      logic [RW-1:0] w_a_nxt;
      logic [RW-1:0] w_b_nxt;
      logic [RW-1:0] r_a;
      logic [RW-1:0] r_b;

      if (k == 0) begin : g_src_in
        assign w_a_nxt = bus.a[N-1:W];
        assign w_b_nxt = w_b_eff[N-1:W];
      end else begin : g_src_prev
        assign w_a_nxt = g_stage[k-1].g_skew.r_a[RW+W-1:W];
        assign w_b_nxt = g_stage[k-1].g_skew.r_b[RW+W-1:W];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_vld_in) begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
        end
      end
    end

`ifdef PRA_OVERFLOW_EN
    // Carry into the MSB is recovered from the MSB operand and sum bits.
    if (k == STAGES-1) begin : g_ovf
      logic r_ovf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv && w_vld_in) begin
          r_ovf <= w_add[W] ^ (w_a[W-1] ^ w_b[W-1] ^ w_add[W-1]);
        end
      end
    end
`endif
  end

  assign bus.out_valid = g_stage[STAGES-1].r_vld;
  assign bus.sum       = g_stage[STAGES-1].r_sum;
  assign bus.c_out     = g_stage[STAGES-1].r_cy;
`ifdef PRA_OVERFLOW_EN
  assign bus.ovf       = g_stage[STAGES-1].g_ovf.r_ovf;
`endif

endmodule
`default_nettype wire
